// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants and types for the BF bracket/loop controller
package bf_pkg;

    localparam int ADDR_W_DEFAULT = 13;

    localparam logic [1:0] OP_OTHER = 2'b00;
    localparam logic [1:0] OP_OPEN  = 2'b01;
    localparam logic [1:0] OP_CLOSE = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SKIP = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNMATCHED = 2'b10;
    localparam logic [1:0] ERR_SKIP_OVF  = 2'b11;

endpackage

// File: rtl/bf_addr_stack.sv
// rtl/bf_addr_stack.sv - LIFO of loop-body start addresses with sync push/pop/clear
module bf_addr_stack
    import bf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     top_idx;

    assign wr_idx  = IW'(count_q);
    assign top_idx = IW'(count_q - CW'(1));

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Meaningless while empty; the controller never consumes it then.
    assign top   = mem_q[top_idx];

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (push && !full) begin
            mem_q[wr_idx] <= push_data;
            count_q       <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/bf_loop_ctrl.sv
// rtl/bf_loop_ctrl.sv - bracket FSM: loop-return stack, forward-skip nesting, jump generation
module bf_loop_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = 8,
    parameter int SKIP_W      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [1:0]                       op_code,
    input  logic                             cell_zero,
    input  logic [ADDR_W-1:0]                pc,
    output logic                             jump,
    output logic [ADDR_W-1:0]                target_addr,
    output logic                             skip,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic [1:0]                       err
);

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic                jump_q, jump_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                skip_q, skip_d;
    logic [1:0]          err_q, err_d;
    logic                push, pop, accept;
    logic [ADDR_W-1:0]   stk_top;
    logic                stk_full, stk_empty;

    bf_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .clear     (rst || flush),
        .push      (push),
        .pop       (pop),
        .push_data (pc + ADDR_W'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (depth)
    );

    assign op_ready    = (state_q != ST_HALT);
    assign accept      = op_valid && op_ready;
    assign jump        = jump_q;
    assign target_addr = target_q;
    assign skip        = skip_q;
    assign err         = err_q;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        jump_d     = 1'b0;
        target_d   = target_q;
        skip_d     = skip_q;
        err_d      = err_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (accept) begin
            case (state_q)
                ST_RUN: begin
                    if (op_code == OP_OPEN) begin
                        if (cell_zero) begin
                            state_d    = ST_SKIP;
                            skip_cnt_d = SKIP_W'(1);
                            skip_d     = 1'b1;
                        end else if (stk_full) begin
                            err_d   = ERR_OVERFLOW;
                            state_d = ST_HALT;
                        end else begin
                            push = 1'b1;
                        end
                    end else if (op_code == OP_CLOSE) begin
                        if (stk_empty) begin
                            err_d   = ERR_UNMATCHED;
                            state_d = ST_HALT;
                        end else if (!cell_zero) begin
                            jump_d   = 1'b1;
                            target_d = stk_top;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                end
                ST_SKIP: begin
                    // Only bracket nesting matters here; cell_zero is stale while skipping.
                    if (op_code == OP_OPEN) begin
                        if (skip_cnt_q == '1) begin
                            err_d   = ERR_SKIP_OVF;
                            state_d = ST_HALT;
                        end else begin
                            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                        end
                    end else if (op_code == OP_CLOSE) begin
                        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                        if (skip_cnt_q == SKIP_W'(1)) begin
                            state_d = ST_RUN;
                            skip_d  = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= ST_RUN;
            skip_cnt_q <= '0;
            jump_q     <= 1'b0;
            target_q   <= '0;
            skip_q     <= 1'b0;
            if (rst) begin
                err_q <= ERR_NONE;
            end
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            jump_q     <= jump_d;
            target_q   <= target_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// tb/tb_bf_loop_ctrl.sv - directed scoreboard bench for bf_loop_ctrl
module tb_bf_loop_ctrl;

    localparam logic [1:0] OTH = 2'b00;
    localparam logic [1:0] OPN = 2'b01;
    localparam logic [1:0] CLS = 2'b10;

    typedef struct {
        logic        j;
        logic [12:0] t;
        logic        s;
        logic [3:0]  d;
        logic [1:0]  e;
        logic        r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = OTH;
    logic        cell_zero = 1'b0;
    logic [12:0] pc = '0;
    logic        jump;
    logic [12:0] target_addr;
    logic        skip;
    logic [3:0]  depth;
    logic [1:0]  err;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    bf_loop_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .cell_zero   (cell_zero),
        .pc          (pc),
        .jump        (jump),
        .target_addr (target_addr),
        .skip        (skip),
        .depth       (depth),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cyc(input logic r, input logic f, input logic v, input logic [1:0] op,
                       input logic cz, input logic [12:0] p, input logic ej,
                       input logic [12:0] et, input logic es, input logic [3:0] ed,
                       input logic [1:0] ee, input logic er);
        exp_t x;
        rst = r; flush = f; op_valid = v; op_code = op; cell_zero = cz; pc = p;
        x.j = ej; x.t = et; x.s = es; x.d = ed; x.e = ee; x.r = er;
        sb.push_back(x);
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; op_valid = 1'b0;
        x = sb.pop_front();
        chk("jump",        32'(jump),        32'(x.j));
        chk("target_addr", 32'(target_addr), 32'(x.t));
        chk("skip",        32'(skip),        32'(x.s));
        chk("depth",       32'(depth),       32'(x.d));
        chk("err",         32'(err),         32'(x.e));
        chk("op_ready",    32'(op_ready),    32'(x.r));
    endtask

    task automatic step(input logic [1:0] op, input logic cz, input logic [12:0] p,
                        input logic ej, input logic [12:0] et, input logic es,
                        input logic [3:0] ed, input logic [1:0] ee, input logic er);
        cyc(1'b0, 1'b0, 1'b1, op, cz, p, ej, et, es, ed, ee, er);
    endtask

    initial begin
        // reset state
        cyc(1'b1, 1'b0, 1'b0, OTH, 1'b0, 13'd0, 0, 13'd0, 0, 4'd0, 2'd0, 1);

        // simple loop
        step(OPN, 0, 13'd5, 0, 13'd0, 0, 4'd1, 2'd0, 1);
        step(CLS, 0, 13'd9, 1, 13'd6, 0, 4'd1, 2'd0, 1);
        step(OTH, 0, 13'd6, 0, 13'd6, 0, 4'd1, 2'd0, 1);
        step(CLS, 1, 13'd9, 0, 13'd6, 0, 4'd0, 2'd0, 1);

        // nested skip
        step(OPN, 1, 13'd2, 0, 13'd6, 1, 4'd0, 2'd0, 1);
        step(OPN, 0, 13'd3, 0, 13'd6, 1, 4'd0, 2'd0, 1);
        step(OTH, 0, 13'd4, 0, 13'd6, 1, 4'd0, 2'd0, 1);
        step(CLS, 0, 13'd5, 0, 13'd6, 1, 4'd0, 2'd0, 1);
        step(CLS, 0, 13'd6, 0, 13'd6, 0, 4'd0, 2'd0, 1);
        step(OPN, 0, 13'd7, 0, 13'd6, 0, 4'd1, 2'd0, 1);
        step(CLS, 0, 13'd8, 1, 13'd8, 0, 4'd1, 2'd0, 1);
        step(CLS, 1, 13'd8, 0, 13'd8, 0, 4'd0, 2'd0, 1);

        // pc wrap
        step(OPN, 0, 13'd8191, 0, 13'd8, 0, 4'd1, 2'd0, 1);
        step(CLS, 0, 13'd100,  1, 13'd0, 0, 4'd1, 2'd0, 1);
        step(CLS, 1, 13'd100,  0, 13'd0, 0, 4'd0, 2'd0, 1);

        // stack overflow, then an op while halted is not accepted
        for (int i = 0; i < 8; i++)
            step(OPN, 0, 13'(20 + i), 0, 13'd0, 0, 4'(i + 1), 2'd0, 1);
        step(OPN, 0, 13'd40, 0, 13'd0, 0, 4'd8, 2'd1, 0);
        step(CLS, 0, 13'd41, 0, 13'd0, 0, 4'd8, 2'd1, 0);
        cyc(1'b1, 1'b0, 1'b0, OTH, 1'b0, 13'd0, 0, 13'd0, 0, 4'd0, 2'd0, 1);

        // unmatched close, flush keeps err, rst clears it
        step(CLS, 0, 13'd1, 0, 13'd0, 0, 4'd0, 2'd2, 0);
        cyc(1'b0, 1'b1, 1'b0, OTH, 1'b0, 13'd0, 0, 13'd0, 0, 4'd0, 2'd2, 1);
        cyc(1'b1, 1'b0, 1'b0, OTH, 1'b0, 13'd0, 0, 13'd0, 0, 4'd0, 2'd0, 1);

        // reset mid-skip with an op presented; counter must restart from zero
        step(OPN, 0, 13'd3, 0, 13'd0, 0, 4'd1, 2'd0, 1);
        step(OPN, 1, 13'd4, 0, 13'd0, 1, 4'd1, 2'd0, 1);
        step(OPN, 1, 13'd5, 0, 13'd0, 1, 4'd1, 2'd0, 1);
        step(OPN, 1, 13'd6, 0, 13'd0, 1, 4'd1, 2'd0, 1);
        cyc(1'b1, 1'b0, 1'b1, OPN, 1'b1, 13'd7, 0, 13'd0, 0, 4'd0, 2'd0, 1);
        step(OPN, 1, 13'd1, 0, 13'd0, 1, 4'd0, 2'd0, 1);
        step(CLS, 0, 13'd2, 0, 13'd0, 0, 4'd0, 2'd0, 1);

        // flush overrides a same-cycle push
        cyc(1'b0, 1'b1, 1'b1, OPN, 1'b0, 13'd3, 0, 13'd0, 0, 4'd0, 2'd0, 1);

        // skip counter saturation: 255 levels ok, 256th '[' errors
        step(OPN, 1, 13'd10, 0, 13'd0, 1, 4'd0, 2'd0, 1);
        for (int i = 1; i < 255; i++)
            step(OPN, 0, 13'(10 + i), 0, 13'd0, 1, 4'd0, 2'd0, 1);
        step(OPN, 0, 13'd300, 0, 13'd0, 1, 4'd0, 2'd3, 0);
        cyc(1'b0, 1'b1, 1'b0, OTH, 1'b0, 13'd0, 0, 13'd0, 0, 4'd0, 2'd3, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
